// File: rtl/ed25519_pkg.sv
// Shared types and constants for the Ed25519 scalar-multiplication ladder controller.
// Contains the point struct, the identity point and the controller state encoding.
package ed25519_pkg;

  localparam int COORD_W  = 255;
  localparam int SCALAR_W = 253;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [COORD_W-1:0] z;
    logic [COORD_W-1:0] t;
  } ext_point_t;

  // Neutral element in extended twisted-Edwards coordinates.
  localparam ext_point_t ID_POINT = '{x: '0, y: COORD_W'(1), z: COORD_W'(1), t: '0};

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DBL_REQ,
    ST_DBL_WAIT,
    ST_ADD_REQ,
    ST_ADD_WAIT,
    ST_NEXT,
    ST_OUT
  } ladder_state_e;

endpackage

// File: rtl/ed25519_op_watchdog.sv
// Per-operation watchdog: down-counter armed by clear, counting while enabled.
// expire fires on the TIMEOUT-th cycle after arming (the arming cycle counts as the first).
module ed25519_op_watchdog #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);
  import ed25519_pkg::*;

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = CNT_W'(TIMEOUT - 2);
    end else if (enable && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  assign expire = enable && (cnt_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ed25519_ladder_ctrl.sv
// MSB-first double-and-add sequencer for the external point-double / point-add units.
// Build option ED25519_CT_LADDER_EN: an add is issued for every bit (result kept only for 1-bits).
//
// state     | meaning
// IDLE      | job_ready high, waiting for a job
// DBL_REQ   | dbl_start pulse, watchdog armed
// DBL_WAIT  | waiting for dbl_done
// ADD_REQ   | add_start pulse, watchdog armed
// ADD_WAIT  | waiting for add_done
// NEXT      | step to the next lower scalar bit or finish
// OUT       | result presented until res_ready
module ed25519_ladder_ctrl #(
  parameter int SCALAR_W = ed25519_pkg::SCALAR_W,
  parameter int COORD_W  = ed25519_pkg::COORD_W,
  parameter int TIMEOUT  = 1024
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                job_valid,
  output logic                job_ready,
  input  logic [SCALAR_W-1:0] job_scalar,
  input  logic [COORD_W-1:0]  job_x,
  input  logic [COORD_W-1:0]  job_y,
  input  logic [COORD_W-1:0]  job_z,
  input  logic [COORD_W-1:0]  job_t,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [COORD_W-1:0]  res_x,
  output logic [COORD_W-1:0]  res_y,
  output logic [COORD_W-1:0]  res_z,
  output logic [COORD_W-1:0]  res_t,
  output logic                res_err,
  output logic [31:0]         res_cycles,
  output logic                busy,
  output logic                dbl_start,
  output logic [COORD_W-1:0]  dbl_x,
  output logic [COORD_W-1:0]  dbl_y,
  output logic [COORD_W-1:0]  dbl_z,
  output logic [COORD_W-1:0]  dbl_t,
  input  logic [COORD_W-1:0]  dbl_rx,
  input  logic [COORD_W-1:0]  dbl_ry,
  input  logic [COORD_W-1:0]  dbl_rz,
  input  logic [COORD_W-1:0]  dbl_rt,
  input  logic                dbl_done,
  output logic                add_start,
  output logic [COORD_W-1:0]  add_p1x,
  output logic [COORD_W-1:0]  add_p1y,
  output logic [COORD_W-1:0]  add_p1z,
  output logic [COORD_W-1:0]  add_p1t,
  output logic [COORD_W-1:0]  add_p2x,
  output logic [COORD_W-1:0]  add_p2y,
  output logic [COORD_W-1:0]  add_p2z,
  output logic [COORD_W-1:0]  add_p2t,
  input  logic [COORD_W-1:0]  add_rx,
  input  logic [COORD_W-1:0]  add_ry,
  input  logic [COORD_W-1:0]  add_rz,
  input  logic [COORD_W-1:0]  add_rt,
  input  logic                add_done
);
  import ed25519_pkg::*;

  localparam int IDX_W = $clog2(SCALAR_W);

  ladder_state_e       state_q, state_d;
  ext_point_t          acc_q, acc_d;
  ext_point_t          base_q, base_d;
  ext_point_t          opnd_q, opnd_d;
  logic [SCALAR_W-1:0] scalar_q, scalar_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                err_q, err_d;
  logic [31:0]         cyc_q, cyc_d;
  logic                wd_clear, wd_en, wd_expire;
  logic                cur_bit, res_ok;

  assign cur_bit = scalar_q[idx_q];

  ed25519_op_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (wd_clear),
    .enable (wd_en),
    .expire (wd_expire)
  );

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    base_d   = base_q;
    opnd_d   = opnd_q;
    scalar_d = scalar_q;
    idx_d    = idx_q;
    err_d    = err_q;
    cyc_d    = cyc_q;
    wd_clear = 1'b0;
    wd_en    = 1'b0;

    if ((state_q != ST_IDLE) && (state_q != ST_OUT) && (cyc_q != '1)) begin
      cyc_d = cyc_q + 32'd1;
    end

    case (state_q)
      ST_IDLE: begin
        if (job_valid) begin
          scalar_d = job_scalar;
          base_d   = '{x: job_x, y: job_y, z: job_z, t: job_t};
          acc_d    = ID_POINT;
          idx_d    = IDX_W'(SCALAR_W - 1);
          cyc_d    = '0;
          err_d    = 1'b0;
          state_d  = ST_DBL_REQ;
        end
      end
      ST_DBL_REQ: begin
        wd_clear = 1'b1;
        state_d  = ST_DBL_WAIT;
      end
      ST_DBL_WAIT: begin
        wd_en = 1'b1;
        if (dbl_done) begin
          acc_d = '{x: dbl_rx, y: dbl_ry, z: dbl_rz, t: dbl_rt};
`ifdef ED25519_CT_LADDER_EN
          state_d = ST_ADD_REQ;
`else
          state_d = cur_bit ? ST_ADD_REQ : ST_NEXT;
`endif
        end else if (wd_expire) begin
          err_d   = 1'b1;
          state_d = ST_OUT;
        end
      end
      ST_ADD_REQ: begin
        wd_clear = 1'b1;
        state_d  = ST_ADD_WAIT;
      end
      ST_ADD_WAIT: begin
        wd_en = 1'b1;
        if (add_done) begin
`ifdef ED25519_CT_LADDER_EN
          if (cur_bit) begin
            acc_d = '{x: add_rx, y: add_ry, z: add_rz, t: add_rt};
          end
`else
          acc_d = '{x: add_rx, y: add_ry, z: add_rz, t: add_rt};
`endif
          state_d = ST_NEXT;
        end else if (wd_expire) begin
          err_d   = 1'b1;
          state_d = ST_OUT;
        end
      end
      ST_NEXT: begin
        if (idx_q == '0) begin
          state_d = ST_OUT;
        end else begin
          idx_d   = idx_q - 1'b1;
          state_d = ST_DBL_REQ;
        end
      end
      ST_OUT: begin
        if (res_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Operands are captured on entry to a request so they hold until done.
    if ((state_d == ST_DBL_REQ) || (state_d == ST_ADD_REQ)) begin
      opnd_d = acc_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      acc_q    <= ID_POINT;
      base_q   <= '0;
      opnd_q   <= '0;
      scalar_q <= '0;
      idx_q    <= '0;
      err_q    <= 1'b0;
      cyc_q    <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      base_q   <= base_d;
      opnd_q   <= opnd_d;
      scalar_q <= scalar_d;
      idx_q    <= idx_d;
      err_q    <= err_d;
      cyc_q    <= cyc_d;
    end
  end

  assign job_ready  = (state_q == ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
  assign dbl_start  = (state_q == ST_DBL_REQ);
  assign add_start  = (state_q == ST_ADD_REQ);
  assign res_valid  = (state_q == ST_OUT);
  assign res_ok     = res_valid && !err_q;
  assign res_err    = res_valid && err_q;
  assign res_cycles = res_valid ? cyc_q : '0;
  assign res_x      = res_ok ? acc_q.x : '0;
  assign res_y      = res_ok ? acc_q.y : '0;
  assign res_z      = res_ok ? acc_q.z : '0;
  assign res_t      = res_ok ? acc_q.t : '0;

  assign dbl_x   = opnd_q.x;
  assign dbl_y   = opnd_q.y;
  assign dbl_z   = opnd_q.z;
  assign dbl_t   = opnd_q.t;
  assign add_p1x = opnd_q.x;
  assign add_p1y = opnd_q.y;
  assign add_p1z = opnd_q.z;
  assign add_p1t = opnd_q.t;
  assign add_p2x = base_q.x;
  assign add_p2y = base_q.y;
  assign add_p2z = base_q.z;
  assign add_p2t = base_q.t;

endmodule

// File: tb/tb_ed25519_ladder_ctrl.sv
// Bench for ed25519_ladder_ctrl: mock double/add responders, table-driven jobs, result scoreboard.
// Expectations follow the ED25519_CT_LADDER_EN build setting.
`timescale 1ns/1ps
module tb_ed25519_ladder_ctrl;

  localparam int SW         = 253;
  localparam int CW         = 255;
  localparam int TB_TIMEOUT = 16;
  localparam int LAT        = 3;
`ifdef ED25519_CT_LADDER_EN
  localparam bit CT = 1'b1;
`else
  localparam bit CT = 1'b0;
`endif

  typedef logic [CW-1:0] coord_t;
  typedef struct packed { coord_t x; coord_t y; coord_t z; coord_t t; } pt_t;

  typedef struct {
    logic [SW-1:0] k;
    pt_t           base;
    bit            hang;
    pt_t           p;
    bit            err;
    int            dbls;
    int            adds;
    logic [31:0]   cyc;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          job_valid = 1'b0, job_ready;
  logic [SW-1:0] job_scalar = '0;
  coord_t        job_x = '0, job_y = '0, job_z = '0, job_t = '0;
  logic          res_valid, res_ready = 1'b1;
  coord_t        res_x, res_y, res_z, res_t;
  logic          res_err, busy;
  logic [31:0]   res_cycles;
  logic          dbl_start, dbl_done = 1'b0;
  coord_t        dbl_x, dbl_y, dbl_z, dbl_t;
  coord_t        dbl_rx = '0, dbl_ry = '0, dbl_rz = '0, dbl_rt = '0;
  logic          add_start, add_done = 1'b0;
  coord_t        add_p1x, add_p1y, add_p1z, add_p1t, add_p2x, add_p2y, add_p2z, add_p2t;
  coord_t        add_rx = '0, add_ry = '0, add_rz = '0, add_rt = '0;

  int checks = 0;
  int errors = 0;

  ed25519_ladder_ctrl #(.TIMEOUT(TB_TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .job_valid(job_valid), .job_ready(job_ready), .job_scalar(job_scalar),
    .job_x(job_x), .job_y(job_y), .job_z(job_z), .job_t(job_t),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_x(res_x), .res_y(res_y), .res_z(res_z), .res_t(res_t),
    .res_err(res_err), .res_cycles(res_cycles), .busy(busy),
    .dbl_start(dbl_start), .dbl_x(dbl_x), .dbl_y(dbl_y), .dbl_z(dbl_z), .dbl_t(dbl_t),
    .dbl_rx(dbl_rx), .dbl_ry(dbl_ry), .dbl_rz(dbl_rz), .dbl_rt(dbl_rt), .dbl_done(dbl_done),
    .add_start(add_start),
    .add_p1x(add_p1x), .add_p1y(add_p1y), .add_p1z(add_p1z), .add_p1t(add_p1t),
    .add_p2x(add_p2x), .add_p2y(add_p2y), .add_p2z(add_p2z), .add_p2t(add_p2t),
    .add_rx(add_rx), .add_ry(add_ry), .add_rz(add_rz), .add_rt(add_rt), .add_done(add_done)
  );

  always #5 clk = ~clk;

  // Mock point units: cheap but coordinate-mixing, and both fix the identity under doubling.
  function automatic pt_t mdbl(input pt_t p);
    pt_t r;
    r.x = p.x << 1;
    r.y = p.y ^ p.t;
    r.z = p.z + p.x;
    r.t = p.t << 1;
    return r;
  endfunction

  function automatic pt_t madd(input pt_t a, input pt_t b);
    pt_t r;
    r.x = a.x + b.x;
    r.y = a.y + b.y;
    r.z = a.z ^ b.z;
    r.t = a.t + b.t;
    return r;
  endfunction

  function automatic pt_t golden(input logic [SW-1:0] k, input pt_t b);
    pt_t acc;
    acc = '{x: '0, y: CW'(1), z: CW'(1), t: '0};
    for (int i = SW - 1; i >= 0; i--) begin
      acc = mdbl(acc);
      if (k[i]) acc = madd(acc, b);
    end
    return acc;
  endfunction

  function automatic vec_t mk(input logic [SW-1:0] k, input pt_t b, input bit hang);
    vec_t v;
    v.k    = k;
    v.base = b;
    v.hang = hang;
    if (hang) begin
      // Hang on the first add: the MSB of k must be set.
      v.p    = '0;
      v.err  = 1'b1;
      v.dbls = 1;
      v.adds = 1;
      v.cyc  = 32'((1 + LAT) + 1 + (TB_TIMEOUT - 1));
    end else begin
      v.p    = golden(k, b);
      v.err  = 1'b0;
      v.dbls = SW;
      v.adds = CT ? SW : $countones(k);
      v.cyc  = 32'(SW * (2 + LAT) + v.adds * (1 + LAT));
    end
    return v;
  endfunction

  task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Responders: sample start on negedge, raise done LAT cycles after the start cycle.
  bit  add_hang = 1'b0;
  int  stab_err = 0;
  int  dbl_dn = 0, add_dn = 0;
  pt_t dbl_lat, add_lat1, add_lat2, tmp_r;

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dbl_dn   = 0;
      dbl_done = 1'b0;
    end else begin
      dbl_done = 1'b0;
      if (dbl_dn > 0) begin
        dbl_dn--;
        if (dbl_dn == 0) begin
          tmp_r = mdbl(dbl_lat);
          {dbl_rx, dbl_ry, dbl_rz, dbl_rt} = tmp_r;
          dbl_done = 1'b1;
          if ({dbl_x, dbl_y, dbl_z, dbl_t} !== dbl_lat) stab_err++;
        end
      end
      if (dbl_start) begin
        dbl_lat = '{x: dbl_x, y: dbl_y, z: dbl_z, t: dbl_t};
        dbl_dn  = LAT;
      end
    end
  end

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      add_dn   = 0;
      add_done = 1'b0;
    end else begin
      add_done = 1'b0;
      if (add_dn > 0) begin
        add_dn--;
        if (add_dn == 0) begin
          tmp_r = madd(add_lat1, add_lat2);
          {add_rx, add_ry, add_rz, add_rt} = tmp_r;
          add_done = 1'b1;
          if ({add_p1x, add_p1y, add_p1z, add_p1t} !== add_lat1) stab_err++;
          if ({add_p2x, add_p2y, add_p2z, add_p2t} !== add_lat2) stab_err++;
        end
      end
      if (add_start) begin
        add_lat1 = '{x: add_p1x, y: add_p1y, z: add_p1z, t: add_p1t};
        add_lat2 = '{x: add_p2x, y: add_p2y, z: add_p2z, t: add_p2t};
        if (!add_hang) add_dn = LAT;
      end
    end
  end

  // Monitor and scoreboard.
  vec_t          sb[$];
  vec_t          e;
  int            n_dbl = 0, n_add = 0, pos_err = 0, cyc_no = 0, last_add_cyc = 0, tot_start = 0;
  logic [SW-1:0] cur_k = '0;

  always @(negedge clk) begin
    cyc_no++;
    if (job_valid && job_ready) begin
      n_dbl = 0; n_add = 0; pos_err = 0; cur_k = job_scalar;
    end
    if (dbl_start) begin n_dbl++; tot_start++; end
    if (add_start) begin
      n_add++; tot_start++;
      last_add_cyc = cyc_no;
      if (n_dbl < 1 || n_dbl > SW) pos_err++;
      else if (!CT && !cur_k[SW - n_dbl]) pos_err++;
    end
    if (res_valid && res_ready) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_result: got res_valid with empty scoreboard, expected none");
      end else begin
        e = sb.pop_front();
        chk("res_x", res_x, e.p.x);
        chk("res_y", res_y, e.p.y);
        chk("res_z", res_z, e.p.z);
        chk("res_t", res_t, e.p.t);
        chk("res_err", res_err, e.err);
        chk("res_cycles", res_cycles, e.cyc);
        chk("dbl_pulses", n_dbl, e.dbls);
        chk("add_pulses", n_add, e.adds);
        chk("add_positions", pos_err, 0);
        if (e.err) begin
          checks++;
          if (cyc_no - last_add_cyc < 1 || cyc_no - last_add_cyc > TB_TIMEOUT) begin
            errors++;
            $display("FAIL timeout_latency: got %0d cycles expected 1..%0d", cyc_no - last_add_cyc, TB_TIMEOUT);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_job(input vec_t v);
    int n;
    sb.push_back(v);
    add_hang   = v.hang;
    job_scalar = v.k;
    job_x = v.base.x; job_y = v.base.y; job_z = v.base.z; job_t = v.base.t;
    job_valid  = 1'b1;
    chk("job_ready_idle", job_ready, 1'b1);
    n = 0;
    while (!job_ready && n < 100) begin tick(); n++; end
    tick();
    job_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 4000) begin tick(); n++; end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout: got %0d pending results expected 0", name, sb.size());
      sb.delete();
    end
  endtask

  vec_t          vecs[6];
  pt_t           b1, b2, b3;
  logic [SW-1:0] k_tmp;
  coord_t        snap_x, snap_t;
  int            n, t0;

  initial begin
    b1 = '{x: CW'(255'h1234_abcd_0000_5555), y: CW'(255'h7777_0001), z: CW'(255'h3), t: CW'(255'h9999_aaaa_bbbb)};
    b2 = '{x: {CW{1'b1}} >> 3, y: CW'(255'hdead_beef), z: CW'(255'hc0ffee), t: CW'(255'h1)};
    b3 = '{x: CW'(255'h5a5a_5a5a_5a5a_5a5a_5a5a), y: CW'(255'h42), z: CW'(255'h1_0000_0001), t: CW'(255'h77)};

    vecs[0] = mk('0, b1, 1'b0);
    vecs[1] = mk(SW'(5), b1, 1'b0);
    k_tmp = '1;
    vecs[2] = mk(k_tmp, b2, 1'b0);
    k_tmp = 253'h1234_5678_9abc_def0_0fed_cba9_8765_4321_1111_2222_3333_4444_5555_6666_7777_8888;
    vecs[3] = mk(k_tmp, b3, 1'b0);
    k_tmp = '0;
    k_tmp[SW-1] = 1'b1;
    vecs[4] = mk(k_tmp, b2, 1'b1);
    vecs[5] = mk(SW'(5), b3, 1'b0);

    // Reset values
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
    chk("rst_job_ready", job_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_res_valid", res_valid, 1'b0);
    chk("rst_res_y", res_y, '0);
    chk("rst_res_cycles", res_cycles, '0);
    chk("rst_dbl_start", dbl_start, 1'b0);
    chk("rst_dbl_y", dbl_y, '0);
    chk("rst_add_p2x", add_p2x, '0);

    for (int i = 0; i < 6; i++) begin
      drive_job(vecs[i]);
      wait_drain("vec_job");
    end
    add_hang = 1'b0;

    // res_ready held low at OUT
    res_ready = 1'b0;
    drive_job(mk(SW'(3), b1, 1'b0));
    n = 0;
    while (!res_valid && n < 4000) begin tick(); n++; end
    chk("stall_res_valid_seen", res_valid, 1'b1);
    snap_x = res_x;
    snap_t = res_t;
    for (int c = 0; c < 20; c++) begin
      tick();
      chk("stall_res_valid", res_valid, 1'b1);
      chk("stall_res_x", res_x, snap_x);
      chk("stall_res_t", res_t, snap_t);
      chk("stall_job_ready", job_ready, 1'b0);
    end
    res_ready = 1'b1;
    tick();
    chk("stall_release_valid", res_valid, 1'b0);
    chk("stall_release_ready", job_ready, 1'b1);
    chk("stall_drained", sb.size(), 0);

    // Reset pulsed during DBL_WAIT
    job_scalar = '1;
    job_x = b2.x; job_y = b2.y; job_z = b2.z; job_t = b2.t;
    job_valid = 1'b1;
    tick();
    job_valid = 1'b0;
    n = 0;
    while (!dbl_start && n < 20) begin tick(); n++; end
    tick();
    chk("pre_reset_busy", busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_busy", busy, 1'b0);
    chk("async_rst_job_ready", job_ready, 1'b1);
    chk("async_rst_dbl_x", dbl_x, '0);
    chk("async_rst_add_p2y", add_p2y, '0);
    chk("async_rst_res_valid", res_valid, 1'b0);
    tick();
    rst_n = 1'b1;
    t0 = tot_start;
    repeat (10) tick();
    chk("post_reset_no_start", tot_start, t0);
    chk("post_reset_idle", job_ready, 1'b1);

    // Recovery after reset
    drive_job(mk(SW'(5), b1, 1'b0));
    wait_drain("post_reset_job");

    chk("operand_stability", stab_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
